// File: rtl/dmem_responder.sv
// dmem_responder: single-request data-memory responder with fixed wait states,
// byte-enable stores, and an error response for misaligned or out-of-range accesses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        we_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  be_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic          accept, enter_resp, acc_we, acc_ok;
    logic [31:0]   acc_addr, acc_wdata;
    logic [3:0]    acc_be;
    logic [AW-1:0] acc_idx;

    assign accept     = req_valid && (state == IDLE);
    assign enter_resp = (state_next == RESP) && (state != RESP) && !reset;

    // With zero wait states the access happens on the accepting edge itself,
    // so the request fields come straight from the inputs.
    assign acc_we    = (state == IDLE) ? req_we    : we_q;
    assign acc_addr  = (state == IDLE) ? req_addr  : addr_q;
    assign acc_wdata = (state == IDLE) ? req_wdata : wdata_q;
    assign acc_be    = (state == IDLE) ? req_be    : be_q;
    assign acc_ok    = (acc_addr[1:0] == 2'b00) && (acc_addr[31:2] < 30'(DEPTH_WORDS));
    assign acc_idx   = acc_addr[AW+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            be_q       <= 4'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end
            if (enter_resp) begin
                resp_rdata <= (acc_ok && !acc_we) ? mem[acc_idx] : 32'd0;
                resp_err   <= !acc_ok;
            end
        end
    end

    // Storage is never reset; an aborted request cannot commit because
    // enter_resp is gated by reset.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_ok && acc_we)
            for (int i = 0; i < 4; i++)
                if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (accept) begin
            state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
            cnt_next   = 4'(WAIT_CYCLES);
        end else if (state == WAIT) begin
            cnt_next   = cnt - 4'd1;
            state_next = (cnt <= 4'd1) ? RESP : WAIT;
        end else if (state == RESP && resp_ready) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        req_ready  = (state == IDLE) && !reset;
        resp_valid = (state == RESP);
        busy       = (state != IDLE);
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of two responders
// (WAIT_CYCLES=2/DEPTH 256 and WAIT_CYCLES=0/DEPTH 16) against a word-array model.
module tb_dmem_responder;
    localparam int D0 = 256, W0 = 2, D1 = 16, W1 = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2], req_ready [2], req_we [2];
    logic        resp_valid [2], resp_ready [2], resp_err [2], busy [2];
    logic [31:0] req_addr [2], req_wdata [2], resp_rdata [2];
    logic [3:0]  req_be [2];

    int tests = 0, fails = 0;
    bit [31:0] mdl [int];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(D0), .WAIT_CYCLES(W0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
        .resp_err(resp_err[0]), .busy(busy[0]));

    dmem_responder #(.DEPTH_WORDS(D1), .WAIT_CYCLES(W1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
        .resp_err(resp_err[1]), .busy(busy[1]));

    function automatic int depth(input int k);
        return k == 0 ? D0 : D1;
    endfunction

    function automatic int waits(input int k);
        return k == 0 ? W0 : W1;
    endfunction

    function automatic bit in_range(input int k, input logic [31:0] a);
        return a[1:0] == 2'b00 && (a >> 2) < depth(k);
    endfunction

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] be);
        bit [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full request/response through one responder, with optional response backpressure.
    task automatic xact(input int k, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input int hold, output logic [31:0] rd);
        int lat, key;
        bit ok, known;
        logic [31:0] r0;
        logic e0;
        ok  = in_range(k, addr);
        key = k * 65536 + int'(addr[17:2]);
        known = ok && mdl.exists(key);
        lat = 0;
        while (!req_ready[k] && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("req_ready_before", req_ready[k], 1);
        req_valid[k] = 1; req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wd; req_be[k] = be;
        @(posedge clk); #1;
        req_valid[k] = 0; req_we[k] = ~we; req_addr[k] = $urandom; req_wdata[k] = $urandom; req_be[k] = 4'($urandom);
        lat = 1;
        while (!resp_valid[k] && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("latency", lat, waits(k) + 1);
        chk("err", resp_err[k], !ok);
        if (!ok || we) chk("rdata_zero", resp_rdata[k], 0);
        else if (known) chk("rdata_load", resp_rdata[k], mdl[key]);
        r0 = resp_rdata[k]; e0 = resp_err[k];
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", resp_valid[k], 1);
            chk("hold_rdata", resp_rdata[k], r0);
            chk("hold_err", resp_err[k], e0);
            chk("hold_req_ready", req_ready[k], 0);
        end
        resp_ready[k] = 1;
        @(posedge clk); #1;
        resp_ready[k] = 0;
        chk("idle_req_ready", req_ready[k], 1);
        chk("idle_resp_valid", resp_valid[k], 0);
        chk("idle_busy", busy[k], 0);
        if (ok && we) begin
            if (known) mdl[key] = merge(mdl[key], wd, be);
            else if (be == 4'hF) mdl[key] = wd;
        end
        rd = r0;
    endtask

    initial begin
        logic [31:0] rd, a, wd;
        int key;
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 0; req_we[k] = 0; req_addr[k] = 0; req_wdata[k] = 0; req_be[k] = 0; resp_ready[k] = 0;
        end
        reset = 1;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_req_ready", req_ready[k], 0);
            chk("rst_resp_valid", resp_valid[k], 0);
            chk("rst_busy", busy[k], 0);
            chk("rst_rdata", resp_rdata[k], 0);
            chk("rst_err", resp_err[k], 0);
        end
        @(posedge clk); #1;
        reset = 0;
        #1;
        chk("post_rst_ready", req_ready[0], 1);

        xact(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd);
        xact(0, 0, 32'h10, 32'h0, 4'h0, 0, rd);
        chk("load_deadbeef", rd, 32'hDEADBEEF);
        xact(0, 1, 32'h20, 32'h11223344, 4'hF, 0, rd);
        xact(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 0, rd);
        xact(0, 0, 32'h20, 32'h0, 4'h0, 0, rd);
        chk("byte_merge", rd, 32'h11BB33DD);
        xact(0, 1, 32'h0, 32'hCAFEF00D, 4'hF, 0, rd);
        xact(0, 0, 32'h13, 32'h0, 4'hF, 0, rd);
        xact(0, 1, 32'h400, 32'h12345678, 4'hF, 0, rd);
        xact(0, 0, 32'h0, 32'h0, 4'h0, 0, rd);
        chk("oor_store_no_effect", rd, 32'hCAFEF00D);
        xact(0, 0, 32'h10, 32'h0, 4'h0, 5, rd);
        xact(0, 1, 32'h8, 32'h0, 4'hF, 0, rd);
        xact(0, 1, 32'h24, 32'h0, 4'b0000, 0, rd);

        // Abort a store two edges after acceptance; reset is held across the
        // edge on which it would otherwise have committed.
        chk("abort_ready", req_ready[0], 1);
        req_valid[0] = 1; req_we[0] = 1; req_addr[0] = 32'h8; req_wdata[0] = 32'h55555555; req_be[0] = 4'hF;
        @(posedge clk); #1;
        req_valid[0] = 0;
        chk("abort_busy_wait", busy[0], 1);
        @(posedge clk); #1;
        reset = 1;
        #1;
        chk("abort_rst_ready", req_ready[0], 0);
        chk("abort_rst_valid", resp_valid[0], 0);
        chk("abort_rst_busy", busy[0], 0);
        chk("abort_rst_rdata", resp_rdata[0], 0);
        chk("abort_rst_err", resp_err[0], 0);
        @(posedge clk); #1;
        chk("abort_rst_valid2", resp_valid[0], 0);
        #2;
        reset = 0;
        #1;
        chk("abort_post_ready", req_ready[0], 1);
        xact(0, 0, 32'h8, 32'h0, 4'h0, 0, rd);
        chk("abort_no_commit", rd, 32'h0);

        // Back-to-back with zero wait states and resp_ready held high.
        resp_ready[1] = 1;
        for (int i = 0; i < 8; i++) begin
            a  = 32'((i / 2) * 4 + ((i == 7) ? 64 : 0));
            wd = $urandom;
            chk("b2b_ready", req_ready[1], 1);
            req_valid[1] = 1; req_we[1] = (i % 2 == 0); req_addr[1] = a; req_wdata[1] = wd; req_be[1] = 4'hF;
            @(posedge clk); #1;
            chk("b2b_resp_valid", resp_valid[1], 1);
            chk("b2b_req_ready_low", req_ready[1], 0);
            chk("b2b_err", resp_err[1], !in_range(1, a));
            key = 65536 + int'(a[17:2]);
            if (i % 2 == 0) begin
                chk("b2b_store_rdata", resp_rdata[1], 0);
                if (in_range(1, a)) mdl[key] = wd;
            end else if (in_range(1, a)) begin
                chk("b2b_load_rdata", resp_rdata[1], mdl[key]);
            end else begin
                chk("b2b_err_rdata", resp_rdata[1], 0);
            end
            @(posedge clk); #1;
        end
        req_valid[1] = 0;
        resp_ready[1] = 0;

        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 8; j++) xact(k, 1, 32'(j * 4), $urandom, 4'hF, 0, rd);
            for (int n = 0; n < 40; n++) begin
                int r;
                r = $urandom_range(0, 9);
                a = (r < 7) ? 32'($urandom_range(0, 7) * 4)
                  : (r == 7) ? 32'($urandom_range(0, 7) * 4 + $urandom_range(1, 3))
                  : 32'(depth(k) * 4 + $urandom_range(0, 15) * 4);
                xact(k, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 2), rd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
